prng_word_gen: RTL

- Parametrised pseudo-random word generator; successor to the fixed 8-bit, 4-bit-seed generator.
- Single Fibonacci LFSR of configurable length, serially harvested into a WIDTH-bit word.
- Word is presented to the consumer (game logic: obstacle/coin placement) over a valid/ready handshake.
- Adds seed load with zero-lockup protection, a clock enable and hold-until-accepted output.

---
 rtl/prng_pkg.sv | 19 +
 rtl/prng_word_gen_if.sv | 11 +
 rtl/prng_word_gen_lfsr_core.sv | 34 +++
 rtl/prng_word_gen.sv | 110 +++++++++++
 4 files changed

// File: rtl/prng_pkg.sv
// Shared types and constants for the pseudo-random word generator.
package prng_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    VALID = 1'b1
  } state_e;

  // Substituted for an all-zero seed so the LFSR can never lock up.
  localparam int unsigned SAFE_SEED = 1;

  localparam logic [7:0]  TAPS8       = 8'hB8;
  localparam logic [7:0]  RESET_SEED8 = 8'hE1;
  localparam logic [15:0] TAPS16       = 16'hB400;
  localparam logic [15:0] RESET_SEED16 = 16'hACE1;
  localparam logic [31:0] TAPS32       = 32'h8020_0003;
  localparam logic [31:0] RESET_SEED32 = 32'hDEAD_BEEF;

endpackage

// File: rtl/prng_word_gen_if.sv
// Word handshake between the generator (master) and the game logic (slave).
interface prng_word_gen_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] out_word;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_word, output out_valid, input out_ready);
  modport slave  (input out_word, input out_valid, output out_ready);
endinterface

// File: rtl/prng_word_gen_lfsr_core.sv
// Fibonacci LFSR: shifts left, feedback enters at bit 0, MSB is the harvested bit.
module lfsr_core
  import prng_pkg::*;
#(
  parameter int                  LFSR_LEN   = 16,
  parameter logic [LFSR_LEN-1:0] TAPS       = TAPS16,
  parameter logic [LFSR_LEN-1:0] RESET_SEED = RESET_SEED16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                step,
  input  logic                load,
  input  logic [LFSR_LEN-1:0] seed,
  output logic                msb_out
);

  logic [LFSR_LEN-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load)
      lfsr_d = (seed == '0) ? LFSR_LEN'(SAFE_SEED) : seed;
    else if (step)
      lfsr_d = {lfsr_q[LFSR_LEN-2:0], ^(lfsr_q & TAPS)};
  end

  always_ff @(posedge clk) begin
    if (!rst) lfsr_q <= RESET_SEED;
    else      lfsr_q <= lfsr_d;
  end

  assign msb_out = lfsr_q[LFSR_LEN-1];

endmodule

// File: rtl/prng_word_gen.sv
// Harvests LFSR bits into WIDTH-bit words and holds each until accepted.
// Optional rejection sampling against 'limit' when RANGE_LIMIT_EN is defined.
module prng_word_gen
  import prng_pkg::*;
#(
  parameter int                  WIDTH      = 8,
  parameter int                  LFSR_LEN   = 16,
  parameter logic [LFSR_LEN-1:0] TAPS       = TAPS16,
  parameter logic [LFSR_LEN-1:0] RESET_SEED = RESET_SEED16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                load,
  input  logic [LFSR_LEN-1:0] seed,
  input  logic [WIDTH-1:0]    limit,
  prng_word_gen_if.master     bus
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             msb;
  logic             step;
  logic [WIDTH-1:0] cand;
  logic             keep;

  assign step = (state_q == FILL) && en;
  assign cand = {sr_q[WIDTH-2:0], msb};

  lfsr_core #(
    .LFSR_LEN  (LFSR_LEN),
    .TAPS      (TAPS),
    .RESET_SEED(RESET_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .step   (step),
    .load   (load),
    .seed   (seed),
    .msb_out(msb)
  );

`ifdef RANGE_LIMIT_EN
  assign keep = (limit == '0) || (cand < limit);
`else
  logic unused_limit;
  assign unused_limit = ^limit;
  assign keep         = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    word_d  = word_q;
    valid_d = valid_q;
    if (load) begin
      // A transfer in the same cycle still completes: valid drops either way.
      cnt_d   = '0;
      valid_d = 1'b0;
      state_d = FILL;
    end else begin
      case (state_q)
        FILL: if (en) begin
          sr_d = cand;
          if (cnt_q == CW'(WIDTH-1)) begin
            cnt_d = '0;
            if (keep) begin
              word_d  = cand;
              valid_d = 1'b1;
              state_d = VALID;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        VALID: if (bus.out_ready) begin
          valid_d = 1'b0;
          state_d = FILL;
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      sr_q    <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign bus.out_word  = word_q;
  assign bus.out_valid = valid_q;

endmodule
